single_port_sync_ram: RTL and testbench
=======================================

# single_port_sync_ram

Single-port synchronous RAM with one shared bidirectional data bus, chip select, write enable and output enable. It is a generic on-chip storage block: a bus master writes words on clock edges and reads them back on the same tri-state bus. Reads are registered, so read data appears one clock after the request. An asynchronous reset clears the array and the read register.

## Interface
- ADDR_WIDTH, 4, address width in bits.
- DATA_WIDTH, 16, word width in bits; the system instance uses 32.
- DEPTH, 16, number of words; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous and active-high.
- addr  input  ADDR_WIDTH  word address.
- data  inout  DATA_WIDTH  shared data bus.
  - Sampled as write data.
  - Driven by the RAM only during a read with output enabled.
- cs  input  1  chip select; active-high.
- we  input  1  write enable; 1 = write, 0 = read.
- oe  input  1  output enable; active-high.

## Operation
- Storage: DEPTH × DATA_WIDTH array `mem`, plus a DATA_WIDTH read register `rd_q`.
- Write: at rising clk with cs=1 and we=1, `mem[addr] <= data`. The oe input is ignored for writes. The external master drives data (it drives while oe=0).
- Read: at rising clk with cs=1 and we=0, `rd_q <= mem[addr]`.
- Bus drive:
  - data = rd_q when cs=1, we=0 and oe=1 (combinational on these controls).
  - Otherwise data = high-Z on all bits.
- Idle: cs=0 means no write, rd_q holds, and the bus is high-Z.
- Reset: while rst=1, every mem word = 0 and rd_q = 0, regardless of clk. Writes and reads are blocked.
- Out-of-range address: not possible, since DEPTH = 2**ADDR_WIDTH. Addresses 0..DEPTH-1 map directly.
- Bus contention: cs=1, we=0, oe=1 while the master also drives data is a system error. The RAM still drives, and it never drives when oe=0.

## Timing
- Write latency: 1 clk; the word is visible to a read issued on the following edge.
- Read latency: 1 clk. A read requested at edge N shows on data after edge N, provided cs, we and oe stay read-enabled.
- Back-to-back reads: one new word per clock, pipelined on consecutive addresses.
- Write followed by read of the same address on the next edge returns the new data.
- Reset mid-operation: takes effect immediately (asynchronous). The first access is honoured at the first rising edge after rst falls.
- Bus after reset with cs=1, we=0, oe=1: drives 0 until the first read edge.

## Structure
- Shared package: the default width and depth constants, and an `mem_word_t` typedef of DATA_WIDTH bits.
- One natural sub-module: `tristate_buf`, a DATA_WIDTH-wide driver taking en and d and producing an inout pad.
- The array, write logic and read register stay in the top module.

## Test plan
- Reset: rst=1 for 2 clocks, then read all 16 addresses with cs=1, we=0, oe=1 -> data = 0x00000000 one clock after each address.
- Write sweep: addr 0..15, cs=1, we=1, oe=0, write a distinct random word per edge -> read sweep with we=0, oe=1 returns each word one clock after its address.
- Tri-state: with cs=0, or oe=0, or we=1 -> data is all Z.
  - Write 0xDEADBEEF to addr 3; read addr 3 with oe=0 -> Z.
  - Raise oe -> 0xDEADBEEF.
- Write-then-read: write 0x12345678 to addr 15, then read addr 15 on the next edge -> 0x12345678 after that edge. Overwrite with 0x0 -> a subsequent read gives 0x0.
- cs gating: write 0xA5A5A5A5 to addr 7 with cs=0 -> a later read of addr 7 returns the previous contents, unchanged.
- Async reset mid-run: after the write sweep, pulse rst between clock edges -> data (while reading) drops to 0 immediately. All addresses read back 0.

Source files
------------

// File: rtl/single_port_sync_ram_pkg.sv
// Shared constants and types for the single-port synchronous RAM.
package single_port_sync_ram_pkg;

    localparam int unsigned DefAddrWidth = 4;
    localparam int unsigned DefDataWidth = 16;
    localparam int unsigned DefDepth     = 2 ** DefAddrWidth;

    typedef logic [DefDataWidth-1:0] mem_word_t;

endpackage

// File: rtl/tristate_buf.sv
// Word-wide tri-state pad driver: drives d_i onto the pad when en_i is set, else releases it.
module tristate_buf #(
    parameter int unsigned Width = 16
) (
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    inout  wire  [Width-1:0] pad_io
);

    assign pad_io = en_i ? d_i : {Width{1'bz}};

endmodule

// File: rtl/single_port_sync_ram.sv
// Single-port synchronous RAM on a shared tri-state data bus with a registered read path.
module single_port_sync_ram
    import single_port_sync_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned DEPTH      = DefDepth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  wr_en;
    logic                  rd_en;
    logic                  drive_en;

    always_comb begin
        wr_en    = cs & we;
        rd_en    = cs & ~we;
        // Bus drive follows the controls combinationally; oe never gates the read itself.
        drive_en = rd_en & oe;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[ADDR_WIDTH'(i)] <= '0;
            end
            rd_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[addr] <= data;
            end
            if (rd_en) begin
                rd_q <= mem_q[addr];
            end
        end
    end

    tristate_buf #(
        .Width (DATA_WIDTH)
    ) u_tristate_buf (
        .en_i   (drive_en),
        .d_i    (rd_q),
        .pad_io (data)
    );

endmodule

// File: tb/tb_single_port_sync_ram.sv
// Scoreboard bench for single_port_sync_ram: reads queue their expected word, popped after the edge.
module tb_single_port_sync_ram;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr;
    logic          cs;
    logic          we;
    logic          oe;
    logic          drv_en;
    logic [DW-1:0] drv_val;
    wire  [DW-1:0] data;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got;
    logic [DW-1:0] expv;
    int            n_cmp = 0;
    int            n_bad = 0;

    // Bus master: when it is not driving, a non-driving RAM leaves the bus released.
    assign data = drv_en ? drv_val : {DW{1'bz}};

    always #5 clk = ~clk;

    single_port_sync_ram #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .data (data),
        .cs   (cs),
        .we   (we),
        .oe   (oe)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_write(input int a, input logic [DW-1:0] w);
        cs = 1'b1; we = 1'b1; oe = 1'b0; addr = AW'(a);
        drv_en = 1'b1; drv_val = w;
        model[a] = w;
    endtask

    task automatic set_read(input int a);
        cs = 1'b1; we = 1'b0; oe = 1'b1; addr = AW'(a);
        drv_en = 1'b0;
        exp_q.push_back(model[a]);
    endtask

    task automatic clear_model();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cs = 1'b0; we = 1'b0; oe = 1'b0; addr = '0; drv_en = 1'b0; drv_val = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cs = 1'b1; we = 1'b0; oe = 1'b1;
        #1;
        n_cmp++;
        if (data !== '0) begin
            n_bad++;
            $display("FAIL bus_after_reset got=%h exp=%h", data, {DW{1'b0}});
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            set_read(i);
            tick();
            got = data; expv = exp_q.pop_front();
            n_cmp++;
            if (got !== expv) begin
                n_bad++;
                $display("FAIL reset_read addr=%0d got=%h exp=%h", i, got, expv);
            end
        end
    endtask

    task automatic test_write_sweep();
        for (int i = 0; i < int'(DEPTH); i++) begin
            set_write(i, {4'(i), 28'($urandom())} | 32'h1);
            tick();
            n_cmp++;
            if (data !== drv_val) begin
                n_bad++;
                $display("FAIL write_bus addr=%0d got=%h exp=%h", i, data, drv_val);
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            set_read(i);
            tick();
            got = data; expv = exp_q.pop_front();
            n_cmp++;
            if (got !== expv) begin
                n_bad++;
                $display("FAIL sweep_read addr=%0d got=%h exp=%h", i, got, expv);
            end
        end
    endtask

    task automatic test_tristate();
        set_write(3, 32'hDEADBEEF);
        tick();
        // Read with oe low: master may legally drive 0; any RAM drive would corrupt it.
        cs = 1'b1; we = 1'b0; oe = 1'b0; addr = 4'd3; drv_en = 1'b1; drv_val = '0;
        exp_q.push_back(model[3]);
        tick();
        n_cmp++;
        if (data !== '0) begin
            n_bad++;
            $display("FAIL oe_low_release got=%h exp=%h", data, {DW{1'b0}});
        end
        drv_en = 1'b0; oe = 1'b1;
        #1;
        got = data; expv = exp_q.pop_front();
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL oe_raise got=%h exp=%h", got, expv);
        end
        cs = 1'b0; drv_en = 1'b1; drv_val = '0;
        #1;
        n_cmp++;
        if (data !== '0) begin
            n_bad++;
            $display("FAIL cs_low_release got=%h exp=%h", data, {DW{1'b0}});
        end
        drv_en = 1'b0;
    endtask

    task automatic test_write_then_read();
        set_write(15, 32'h12345678);
        tick();
        set_read(15);
        tick();
        got = data; expv = exp_q.pop_front();
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL wr_then_rd got=%h exp=%h", got, expv);
        end
        set_write(15, 32'h0);
        tick();
        set_read(15);
        tick();
        got = data; expv = exp_q.pop_front();
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL overwrite_zero got=%h exp=%h", got, expv);
        end
    endtask

    task automatic test_cs_gating();
        cs = 1'b0; we = 1'b1; oe = 1'b0; addr = 4'd7; drv_en = 1'b1; drv_val = 32'hA5A5A5A5;
        tick();
        set_read(7);
        tick();
        got = data; expv = exp_q.pop_front();
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL cs_gating got=%h exp=%h", got, expv);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            set_write(i, {4'(i), 28'($urandom())} | 32'h1);
            tick();
        end
        set_read(5);
        tick();
        got = data; expv = exp_q.pop_front();
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL pre_reset_read got=%h exp=%h", got, expv);
        end
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (data !== '0) begin
            n_bad++;
            $display("FAIL async_clear got=%h exp=%h", data, {DW{1'b0}});
        end
        #1 rst = 1'b0;
        clear_model();
        for (int i = 0; i < int'(DEPTH); i++) begin
            set_read(i);
            tick();
            got = data; expv = exp_q.pop_front();
            n_cmp++;
            if (got !== expv) begin
                n_bad++;
                $display("FAIL post_reset_read addr=%0d got=%h exp=%h", i, got, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_sweep();
        test_tristate();
        test_write_then_read();
        test_cs_gating();
        test_async_reset();
        cs = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
